// File: rtl/boot_copy_pkg.sv
// rtl/boot_copy_pkg.sv - shared state encoding and default parameters for boot_copy
// Purpose : state enumeration and default parameter constants for the boot copier.
// Ports   : none (package).
package boot_copy_pkg;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          DEF_AW              = 14;
    localparam int          DEF_NSRC            = 2;
    localparam int          DEF_DW              = 8;
    localparam int          DEF_SLOTS           = 4;
    localparam int          DEF_RF_SLOT         = 1;
    localparam int          DEF_DAW             = 16;
    localparam logic [15:0] DEF_BASE            = 16'h0000;
    localparam bit          DEF_RESTART_ON_LOSS = 1'b1;

endpackage

// File: rtl/boot_copy.sv
// rtl/boot_copy.sv - copies NSRC source regions into destination memory at boot
// Purpose : walks a {region, word, slot} counter, reads each source word and writes it
//           to BASE + {region, word}, with a refresh slot per word; done = init flag.
// Ports   : clock, reset (sync, active-low), ce (clock enable), ready (dest ready),
//           restart (re-run request in DONE), src_q (packed region data) ->
//           src_a / src_sel (source address / region), dst_a / dst_d / dst_we / dst_rf
//           (destination address, data, write and refresh strobes), busy, done.
module boot_copy
    import boot_copy_pkg::*;
#(
    parameter int             AW              = DEF_AW,
    parameter int             NSRC            = DEF_NSRC,
    parameter int             DW              = DEF_DW,
    parameter int             SLOTS           = DEF_SLOTS,
    parameter int             RF_SLOT         = DEF_RF_SLOT,
    parameter int             DAW             = DEF_DAW,
    parameter logic [DAW-1:0] BASE            = DAW'(DEF_BASE),
    parameter bit             RESTART_ON_LOSS = DEF_RESTART_ON_LOSS,
    localparam int            RW              = (NSRC > 1) ? $clog2(NSRC) : 0,
    localparam int            RWS             = (RW > 0) ? RW : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 ready,
    input  logic                 restart,
    input  logic [NSRC*DW-1:0]   src_q,
    output logic [AW-1:0]        src_a,
    output logic [RWS-1:0]       src_sel,
    output logic [DAW-1:0]       dst_a,
    output logic [DW-1:0]        dst_d,
    output logic                 dst_we,
    output logic                 dst_rf,
    output logic                 busy,
    output logic                 done
);

    localparam int SW = $clog2(SLOTS);
    localparam int IW = AW + RW;
    localparam int CW = AW + RW + SW;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [SW-1:0]   w_slot;
    logic [AW-1:0]   w_word;
    logic [RWS-1:0]  w_region;
    logic [IW-1:0]   w_idx;
    logic            w_last;
    logic            w_copy;
    logic [DW-1:0]   w_rdata;

    assign w_slot = r_cnt[SW-1:0];
    assign w_word = r_cnt[SW +: AW];
    assign w_idx  = r_cnt[CW-1:SW];
    assign w_last = &r_cnt;
    assign w_copy = (r_state == COPY);

    generate
        if (RW > 0) begin : g_region
            assign w_region = r_cnt[CW-1 -: RW];
        end else begin : g_single
            assign w_region = '0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Ready loss and restart act on the very next edge, independent of ce;
    // all forward progress of the copy waits for a ce tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            WAIT: begin
                w_cnt_nxt = '0;
                if (ce && ready) begin
                    w_state_nxt = COPY;
                end
            end
            COPY: begin
                if (!ready) begin
                    if (RESTART_ON_LOSS) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = '0;
                    end
                end else if (ce) begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            DONE: begin
                if (restart) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_rdata = src_q[DW-1:0];
        for (int k = 1; k < NSRC; k++) begin
            if (w_region == RWS'(k)) begin
                w_rdata = src_q[k*DW +: DW];
            end
        end
    end

    // Outputs are gated by reset so they hold their idle values for the whole
    // reset interval, including before the first clock edge.
    assign busy    = reset && w_copy;
    assign done    = reset && (r_state == DONE);
    assign dst_we  = reset && w_copy && ready && (w_slot == SW'(SLOTS - 1));
    assign dst_rf  = reset && w_copy && (w_slot == SW'(RF_SLOT));
    assign src_a   = reset ? w_word : '0;
    assign src_sel = reset ? w_region : '0;
    assign dst_a   = reset ? (BASE + DAW'(w_idx)) : BASE;
    assign dst_d   = w_rdata;

endmodule

// File: tb/tb_boot_copy.sv
// tb/tb_boot_copy.sv - self-checking bench for boot_copy against a word/slot reference model
module tb_boot_copy;

    localparam int N      = 3;
    localparam int TOTAL  = 128;
    localparam int M_WAIT = 0;
    localparam int M_COPY = 1;
    localparam int M_DONE = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        ce;
    logic        ready;
    logic        restart;

    logic [15:0] src_q   [N];
    logic [3:0]  src_a   [N];
    logic [0:0]  src_sel [N];
    logic [15:0] dst_a   [N];
    logic [7:0]  dst_d   [N];
    logic        dst_we  [N];
    logic        dst_rf  [N];
    logic        busy    [N];
    logic        done    [N];

    logic [7:0]  mem [N][2][16];

    int          checks   = 0;
    int          failures = 0;
    int          m_mode [N];
    int          m_pos  [N];
    int          wr_cnt [N];
    logic [15:0] wr_log [N][$];

    always #5 clock = ~clock;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            assign src_q[g] = {mem[g][1][src_a[g]], mem[g][0][src_a[g]]};
            boot_copy #(
                .AW              (4),
                .NSRC            (2),
                .DW              (8),
                .SLOTS           (4),
                .RF_SLOT         (1),
                .DAW             (16),
                .BASE            ((g == 2) ? 16'hFFF0 : 16'h0100),
                .RESTART_ON_LOSS (g != 1)
            ) u_dut (
                .clock   (clock),
                .reset   (reset),
                .ce      (ce),
                .ready   (ready),
                .restart (restart),
                .src_q   (src_q[g]),
                .src_a   (src_a[g]),
                .src_sel (src_sel[g]),
                .dst_a   (dst_a[g]),
                .dst_d   (dst_d[g]),
                .dst_we  (dst_we[g]),
                .dst_rf  (dst_rf[g]),
                .busy    (busy[g]),
                .done    (done[g])
            );
        end
    endgenerate

    function automatic bit loss_restarts(input int i);
        return i != 1;
    endfunction

    function automatic int base_of(input int i);
        return (i == 2) ? 'hFFF0 : 'h0100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs follow from the copy position: word index = pos / SLOTS,
    // slot = pos % SLOTS, region = word index / 16.
    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            int       widx;
            int       slot;
            logic [3:0] e_ctl;
            if (!reset) begin
                chk($sformatf("d%0d_rst_ctl", i), {busy[i], done[i], dst_we[i], dst_rf[i]}, 4'b0000);
                chk($sformatf("d%0d_rst_src", i), {src_sel[i], src_a[i]}, 5'd0);
                chk($sformatf("d%0d_rst_dst_a", i), dst_a[i], 32'(base_of(i)));
            end else begin
                widx  = m_pos[i] / 4;
                slot  = m_pos[i] % 4;
                e_ctl = {m_mode[i] == M_COPY, m_mode[i] == M_DONE,
                         m_mode[i] == M_COPY && ready && slot == 3,
                         m_mode[i] == M_COPY && slot == 1};
                chk($sformatf("d%0d_ctl", i), {busy[i], done[i], dst_we[i], dst_rf[i]}, e_ctl);
                chk($sformatf("d%0d_src", i), {src_sel[i], src_a[i]}, 32'(widx));
                chk($sformatf("d%0d_dst_a", i), dst_a[i], 32'((base_of(i) + widx) % 65536));
                chk($sformatf("d%0d_dst_d", i), dst_d[i], mem[i][widx / 16][widx % 16]);
            end
            chk($sformatf("d%0d_we_rf_overlap", i), dst_we[i] & dst_rf[i], 1'b0);
            if (reset && dst_we[i] && ce) begin
                wr_cnt[i]++;
                wr_log[i].push_back(dst_a[i]);
            end
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            if (!reset) begin
                m_mode[i] = M_WAIT;
                m_pos[i]  = 0;
            end else if (m_mode[i] == M_WAIT) begin
                if (ce && ready) m_mode[i] = M_COPY;
            end else if (m_mode[i] == M_COPY) begin
                if (!ready) begin
                    if (loss_restarts(i)) begin
                        m_mode[i] = M_WAIT;
                        m_pos[i]  = 0;
                    end
                end else if (ce) begin
                    if (m_pos[i] == TOTAL - 1) m_mode[i] = M_DONE;
                    else m_pos[i]++;
                end
            end else if (restart) begin
                m_mode[i] = M_WAIT;
                m_pos[i]  = 0;
            end
        end
    endtask

    task automatic cyc();
        #1;
        check_outputs();
        @(posedge clock);
        model_step();
        #2;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < N; i++) begin
            wr_cnt[i] = 0;
            wr_log[i].delete();
        end
    endtask

    function automatic int seq_bad(input int i, input int from, input int n, input int start_addr);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            if (from + k >= wr_log[i].size()) bad++;
            else if (wr_log[i][from + k] != 16'((start_addr + k) % 65536)) bad++;
        end
        return bad;
    endfunction

    function automatic logic [15:0] log_at(input int i, input int k);
        if (k < wr_log[i].size()) return wr_log[i][k];
        return 16'hDEAD;
    endfunction

    task automatic run_copy(input string tag, input int budget, input int ce_div,
                            output int t_busy, output int t_done);
        t_busy = -1;
        t_done = -1;
        for (int n = 0; n < budget; n++) begin
            ce = (n % ce_div == 0);
            cyc();
            if (busy[0] && t_busy < 0) t_busy = n;
            if (done[0] && t_done < 0) t_done = n;
            if (done[0] && done[1] && done[2]) break;
        end
        ce = 1'b1;
        chk({tag, "_all_done"}, {done[0], done[1], done[2]}, 3'b111);
    endtask

    task automatic pulse_restart();
        ce      = 1'b1;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
    endtask

    initial begin
        int  tb;
        int  td;
        bit  dropped;
        bit  pulsed;
        int  drop;

        for (int i = 0; i < N; i++)
            for (int r = 0; r < 2; r++)
                for (int w = 0; w < 16; w++)
                    mem[i][r][w] = 8'($urandom);

        reset   = 1'b0;
        ce      = 1'b1;
        ready   = 1'b0;
        restart = 1'b0;
        clear_logs();
        for (int n = 0; n < 3; n++) cyc();

        // Plain copy with ready high from reset release.
        reset = 1'b1;
        ready = 1'b1;
        run_copy("s1", 300, 1, tb, td);
        chk("s1_done_latency", td - tb, 128);
        chk("s1_wr_cnt0", wr_cnt[0], 32);
        chk("s1_seq0", seq_bad(0, 0, 32, 'h0100), 0);
        chk("s1_wr_cnt2", wr_cnt[2], 32);
        chk("s1_wrap_last", log_at(2, 15), 16'hFFFF);
        chk("s1_wrap_first", log_at(2, 16), 16'h0000);
        chk("s1_seq2", seq_bad(2, 0, 32, 'hFFF0), 0);

        // Restart from DONE, ready loss after write 10, restart mid-copy.
        pulse_restart();
        chk("s2_done_fall", done[0], 1'b0);
        clear_logs();
        dropped = 1'b0;
        pulsed  = 1'b0;
        drop    = 0;
        for (int n = 0; n < 800; n++) begin
            ready = (drop == 0);
            if (drop > 0) drop--;
            restart = (!pulsed && wr_cnt[1] == 20);
            if (restart) pulsed = 1'b1;
            cyc();
            if (restart) chk("s2_restart_ignored", {busy[0], busy[1]}, 2'b11);
            restart = 1'b0;
            if (!dropped && wr_cnt[0] == 10) begin
                dropped = 1'b1;
                drop    = 3;
            end
            if (done[0] && done[1] && done[2]) break;
        end
        ready = 1'b1;
        chk("s2_all_done", {done[0], done[1], done[2]}, 3'b111);
        chk("s2_wr_cnt_restart", wr_cnt[0], 42);
        chk("s2_seq_restart_a", seq_bad(0, 0, 10, 'h0100), 0);
        chk("s2_seq_restart_b", seq_bad(0, 10, 32, 'h0100), 0);
        chk("s2_wr_cnt_freeze", wr_cnt[1], 32);
        chk("s2_resume_addr", log_at(1, 10), 16'h010A);
        chk("s2_seq_freeze", seq_bad(1, 0, 32, 'h0100), 0);

        // ce one cycle in three.
        pulse_restart();
        clear_logs();
        run_copy("s3", 1200, 3, tb, td);
        chk("s3_done_latency", td - tb, 384);
        chk("s3_wr_cnt0", wr_cnt[0], 32);
        chk("s3_seq0", seq_bad(0, 0, 32, 'h0100), 0);

        // Reset in the middle of a copy.
        pulse_restart();
        for (int n = 0; n < 20; n++) cyc();
        chk("s4_pre_abort_busy", busy[0], 1'b1);
        reset = 1'b0;
        cyc();
        chk("s4_abort", {busy[0], dst_we[0], dst_a[0]}, {2'b00, 16'h0100});
        reset = 1'b1;

        // Randomised ready / ce / restart / reset traffic.
        for (int n = 0; n < 1500; n++) begin
            ready   = ($urandom_range(0, 15) != 0);
            ce      = ($urandom_range(0, 2) != 0);
            restart = ($urandom_range(0, 40) == 0);
            reset   = ($urandom_range(0, 400) != 0);
            cyc();
        end
        reset   = 1'b1;
        restart = 1'b0;
        ready   = 1'b1;
        ce      = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boot_copy.md
BOOT_COPY -- requirements
Module: boot_copy

Interface
REQ-001 Parameter AW, default 14: address width of one source region; each region holds 2^AW words.
REQ-002 Parameter NSRC, default 2: number of source regions (power of 2, minimum 1); RW = clog2(NSRC), with RW = 0 when NSRC = 1.
REQ-003 Parameter DW, default 8: data word width.
REQ-004 Parameter SLOTS, default 4: ce ticks per copied word (power of 2, minimum 4); SW = clog2(SLOTS).
REQ-005 Parameter RF_SLOT, default 1: slot index in which the refresh strobe is issued (0 to SLOTS-2).
REQ-006 Parameter DAW, default 16, and BASE, default 0: destination address width and destination offset.
REQ-007 Parameter RESTART_ON_LOSS, default 1: 1 = a ready loss restarts the copy; 0 = a ready loss freezes it.
REQ-008 clock  in  1  system clock; one clock.
REQ-009 reset  in  1  synchronous, active-low reset.
REQ-010 ce  in  1  clock enable; all state advances only on clock edges with ce = 1.
REQ-011 ready  in  1  destination memory ready.
REQ-012 restart  in  1  single-cycle request to re-run the copy.
REQ-013 src_q  in  NSRC*DW  packed read data from all regions; region k is bits [k*DW +: DW].
REQ-014 src_a  out  AW  source word address.
REQ-015 src_sel  out  max(RW,1)  current region index.
REQ-016 dst_a  out  DAW  destination address.
REQ-017 dst_d  out  DW  destination write data.
REQ-018 dst_we  out  1  active-high write strobe.
REQ-019 dst_rf  out  1  active-high refresh strobe.
REQ-020 busy  out  1  high while in COPY.
REQ-021 done  out  1  high in DONE; functions as the system init flag.

Function
REQ-022 The block SHALL have an internal counter cnt of width AW+RW+SW, split MSB to LSB as {region, word, slot}.
REQ-023 The FSM SHALL have three states: WAIT, COPY and DONE.
REQ-024 WAIT: cnt is 0; on a ce tick with ready = 1 the FSM SHALL move to COPY.
REQ-025 COPY: on each ce tick with ready = 1, cnt SHALL increment by 1.
REQ-026 COPY to DONE SHALL occur on the ce tick at which cnt equals all-ones; cnt then holds at all-ones.
REQ-027 src_a SHALL equal word, src_sel SHALL equal region, and dst_d SHALL equal the src_q slice selected by region.
REQ-028 dst_a SHALL equal (BASE + {region, word}) modulo 2^DAW; wrap-around is silent.
REQ-029 dst_we SHALL be asserted when state is COPY, ready = 1 and slot = SLOTS-1; this gives the source SLOTS-1 ticks of read latency.
REQ-030 dst_rf SHALL be asserted when state is COPY and slot = RF_SLOT.
REQ-031 dst_we and dst_rf SHALL be held for the whole ce period of their slot and SHALL never be high together.
REQ-032 Ready loss in COPY with RESTART_ON_LOSS = 1: the FSM SHALL go to WAIT with cnt = 0 on the next clock edge, regardless of ce.
REQ-033 Ready loss in COPY with RESTART_ON_LOSS = 0: cnt SHALL freeze, dst_we SHALL be low, and the copy SHALL resume from the same cnt when ready returns.
REQ-034 In DONE, ready is ignored and done stays high.
REQ-035 restart in DONE SHALL move the FSM to WAIT with cnt = 0 on the next clock edge; restart in WAIT or COPY SHALL be ignored.
REQ-036 When restart and a ready loss occur in the same cycle, the ready-loss rule SHALL take precedence.

Reset
REQ-037 With reset = 0 at a clock edge, the block SHALL enter WAIT with cnt = 0, independent of ce.
REQ-038 While in reset, outputs SHALL be: busy = 0, done = 0, dst_we = 0, dst_rf = 0, src_a = 0, src_sel = 0, dst_a = BASE.
REQ-039 Reset mid-COPY SHALL abort the copy with no further write strobes.

Structure
REQ-040 Package boot_copy_pkg SHALL hold the state enumeration (WAIT, COPY, DONE) and the default parameter constants.
REQ-041 The design SHALL need no sub-module; the slot decode is inline.

Verification
All scenarios use AW=4, NSRC=2, SLOTS=4, RF_SLOT=1, BASE=16'h0100, with ce every cycle.
REQ-042 Ready high from reset release -> exactly 32 dst_we pulses, dst_a stepping 0x0100 to 0x011F, dst_d equal to region0 then region1 data; done rises 128 ticks after COPY entry.
REQ-043 RESTART_ON_LOSS=1, ready dropped for 3 cycles after write 10 -> cnt returns to 0; the 32 writes repeat from dst_a 0x0100; done only after a full uninterrupted pass.
REQ-044 RESTART_ON_LOSS=0, same ready drop -> no dst_we while ready is low; writes resume at dst_a 0x010A; 32 distinct addresses are written in total.
REQ-045 restart pulsed in DONE -> done falls the next cycle and a second complete 32-word copy follows; restart pulsed mid-COPY -> no effect.
REQ-046 ce asserted 1 cycle in 3 -> same write sequence as REQ-042, 384 clocks long; dst_we and dst_rf never overlap.
REQ-047 BASE=16'hFFF0 -> dst_a wraps from 0xFFFF to 0x0000 at word 16.
